// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command controller:
// opcodes, frame/header field positions, FSM encoding.
package spi_cmd_pkg;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_WRITE  = 4'h1;
  localparam logic [3:0] OPC_READ   = 4'h2;
  localparam logic [3:0] OPC_START  = 4'h3;
  localparam logic [3:0] OPC_STATUS = 4'h4;

  // Bit positions inside the top byte of a frame,
  // counted from DATA_W upward.
  localparam int OPC_MSB  = 7;
  localparam int ADDR_MSB = 3;

  // Response header bit positions.
  localparam int HDR_SEQ_LSB = 4;
  localparam int HDR_ERR     = 3;
  localparam int HDR_BUSY    = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Frame bundle between SPI slave (master modport) and
// command controller (slave modport): RECEIVED, RXED, TO_SEND.
interface spi_cmd_ctrl_if #(
  parameter int DATA_W = 128
);
  logic [DATA_W+7:0] RECEIVED;
  logic              RXED;
  logic [DATA_W+7:0] TO_SEND;

  modport master (
    output RECEIVED,
    output RXED,
    input  TO_SEND
  );

  modport slave (
    input  RECEIVED,
    input  RXED,
    output TO_SEND
  );
endinterface

// File: rtl/spi_cfg_regfile.sv
// NREG x DATA_W config bank: one write port, one comb read
// port, flattened cfg output, synchronous reset to zero.
module spi_cfg_regfile #(
  parameter int DATA_W = 128,
  parameter int NREG   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [3:0]             addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [NREG*DATA_W-1:0] cfg
);

  logic [NREG*DATA_W-1:0] cfg_q, cfg_d;

  // Addresses >= NREG match no entry: read 0, no write.
  always_comb begin
    cfg_d = cfg_q;
    rdata = '0;
    for (int k = 0; k < NREG; k++) begin
      if (addr == 4'(k)) begin
        rdata = cfg_q[k*DATA_W +: DATA_W];
        if (we) begin
          cfg_d[k*DATA_W +: DATA_W] = wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign cfg = cfg_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI frames, executes them on the config bank,
// pulses START, stages the response on frm.TO_SEND.
// Ports: CLK, RESET, frm (slave), BUSY_IN, STAT_IN,
// CFG, START, ERR_CNT.
module spi_cmd_ctrl #(
  parameter int DATA_W = 128,
  parameter int NREG   = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  spi_cmd_ctrl_if.slave          frm,
  input  logic                   BUSY_IN,
  input  logic [DATA_W-1:0]      STAT_IN,
  output logic [NREG*DATA_W-1:0] CFG,
  output logic                   START,
  output logic [7:0]             ERR_CNT
);
  import spi_cmd_pkg::*;

  localparam int LENGTH = DATA_W + 8;
  localparam logic [4:0] NREG5 = 5'(NREG);

  logic              rxed_dly_q, rxed_dly_d;
  logic [2:0]        state_q, state_d;
  logic [LENGTH-1:0] cmd_q, cmd_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LENGTH-1:0] resp_q, resp_d;
  logic [LENGTH-1:0] to_send_q, to_send_d;
  logic [3:0]        seq_q, seq_d;
  logic              start_q, start_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [3:0]        opc, addr;
  logic [DATA_W-1:0] data, rf_rdata, dec_rdata;
  logic              rise, addr_bad, dec_err, we;

  assign opc  = cmd_q[DATA_W+OPC_MSB -: 4];
  assign addr = cmd_q[DATA_W+ADDR_MSB -: 4];
  assign data = cmd_q[DATA_W-1:0];
  assign rise = frm.RXED & ~rxed_dly_q;
  assign addr_bad = {1'b0, addr} >= NREG5;

  assign we = (state_q == ST_EXEC) &&
              (opc == OPC_WRITE) && !err_q;

  spi_cfg_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk   (CLK),
    .rst   (RESET),
    .we    (we),
    .addr  (addr),
    .wdata (data),
    .rdata (rf_rdata),
    .cfg   (CFG)
  );

  // Errors force RDATA to zero: only good paths load it.
  always_comb begin
    dec_err   = 1'b0;
    dec_rdata = '0;
    unique case (opc)
      OPC_NOP: ;
      OPC_WRITE: begin
        if (addr_bad) dec_err = 1'b1;
        else dec_rdata = data;
      end
      OPC_READ: begin
        if (addr_bad) dec_err = 1'b1;
        else dec_rdata = rf_rdata;
      end
      OPC_START:  dec_err = BUSY_IN;
      OPC_STATUS: dec_rdata = STAT_IN;
      default:    dec_err = 1'b1;
    endcase
  end

  always_comb begin
    rxed_dly_d = frm.RXED;
    state_d    = state_q;
    cmd_d      = cmd_q;
    err_d      = err_q;
    busy_d     = busy_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    to_send_d  = to_send_q;
    seq_d      = seq_q;
    start_d    = 1'b0;
    err_cnt_d  = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cmd_d   = frm.RECEIVED;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        err_d   = dec_err;
        busy_d  = BUSY_IN;
        rdata_d = dec_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        start_d = (opc == OPC_START) && !err_q;
        if (err_q && err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
        resp_d  = {seq_q, err_q, busy_q,
                   opc[1:0], rdata_q};
        state_d = ST_WAIT;
      end
      // Level test also covers a fall seen during DECODE/EXEC.
      ST_WAIT: begin
        if (!frm.RXED) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        to_send_d = resp_q;
        seq_d     = seq_q + 4'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Delay reg resets high: a frame already complete at
  // reset release is not seen as a new rise.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxed_dly_q <= 1'b1;
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
      to_send_q  <= '0;
      seq_q      <= '0;
      start_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      rxed_dly_q <= rxed_dly_d;
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      to_send_q  <= to_send_d;
      seq_q      <= seq_d;
      start_q    <= start_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign frm.TO_SEND = to_send_q;
  assign START       = start_q;
  assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: write/read, start,
// errors, status timing, saturation, seq wrap, reset abort.
module tb_spi_cmd_ctrl;

  localparam int DW   = 128;
  localparam int NREG = 4;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic                 BUSY_IN = 1'b0;
  logic [DW-1:0]        STAT_IN = '0;
  logic [NREG*DW-1:0]   CFG;
  logic                 START;
  logic [7:0]           ERR_CNT;

  int checks = 0;
  int errors = 0;
  int n_start = 0;

  spi_cmd_ctrl_if #(.DATA_W(DW)) bus();

  spi_cmd_ctrl #(
    .DATA_W (DW),
    .NREG   (NREG)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .frm     (bus.slave),
    .BUSY_IN (BUSY_IN),
    .STAT_IN (STAT_IN),
    .CFG     (CFG),
    .START   (START),
    .ERR_CNT (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (START) n_start++;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int k);
    return CFG[k*DW +: DW];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input logic [3:0] opc,
                       input logic [3:0] a,
                       input logic [DW-1:0] d);
    bus.RECEIVED = {opc, a, d};
    bus.RXED = 1'b1;
  endtask

  task automatic frame(input logic [3:0] opc,
                       input logic [3:0] a,
                       input logic [DW-1:0] d,
                       input int hold);
    drive(opc, a, d);
    tick(hold);
    bus.RXED = 1'b0;
    tick(4);
  endtask

  logic [3:0] exp_seq;
  int         s0;

  initial begin
    bus.RXED = 1'b1;
    bus.RECEIVED = {4'h1, 4'h0, {16{8'hA5}}};
    tick(3);
    RESET = 1'b0;
    tick(6);
    check("rst_cfg", CFG, '0);
    check("rst_errcnt", ERR_CNT, 8'd0);
    check("rst_tosend", bus.TO_SEND, '0);
    check("rst_start", START, 1'b0);
    bus.RXED = 1'b0;
    tick(4);
    check("held_frame_cfg", CFG, '0);
    check("held_frame_tosend", bus.TO_SEND, '0);

    drive(4'h1, 4'h2, 128'h1234);
    tick(2);
    check("wr_t2", reg_of(2), '0);
    tick(1);
    check("wr_t3", reg_of(2), 128'h1234);
    tick(2);
    bus.RXED = 1'b0;
    tick(1);
    check("wr_tx_old", bus.TO_SEND, '0);
    tick(1);
    check("wr_tx", bus.TO_SEND, {8'h01, 128'h1234});
    tick(2);
    frame(4'h2, 4'h2, 128'h0, 4);
    check("rd_tx", bus.TO_SEND, {8'h12, 128'h1234});

    s0 = n_start;
    drive(4'h3, 4'h0, 128'h0);
    tick(2);
    check("st_t2", START, 1'b0);
    tick(1);
    check("st_t3", START, 1'b1);
    tick(1);
    check("st_t4", START, 1'b0);
    bus.RXED = 1'b0;
    tick(4);
    check("st_count", n_start - s0, 1);
    check("st_tx", bus.TO_SEND, {8'h23, 128'h0});

    BUSY_IN = 1'b1;
    s0 = n_start;
    frame(4'h3, 4'h0, 128'h0, 4);
    BUSY_IN = 1'b0;
    check("stb_count", n_start - s0, 0);
    check("stb_errcnt", ERR_CNT, 8'd1);
    check("stb_tx", bus.TO_SEND, {8'h3F, 128'h0});

    frame(4'h1, 4'h7, 128'h5555, 4);
    check("wr7_tx", bus.TO_SEND, {8'h49, 128'h0});
    frame(4'hF, 4'h0, 128'h7777, 4);
    check("opf_tx", bus.TO_SEND, {8'h5B, 128'h0});
    check("bad_errcnt", ERR_CNT, 8'd3);
    check("bad_cfg", CFG, {128'h0, 128'h1234,
                           128'h0, 128'h0});

    STAT_IN = 128'hDEAD_BEEF;
    drive(4'h4, 4'h0, 128'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("stat_hold", bus.TO_SEND, {8'h5B, 128'h0});
    end
    bus.RXED = 1'b0;
    tick(1);
    check("stat_fall1", bus.TO_SEND, {8'h5B, 128'h0});
    tick(1);
    check("stat_fall2", bus.TO_SEND,
          {8'h60, 128'hDEAD_BEEF});
    tick(2);

    exp_seq = 4'd7;
    for (int i = 0; i < 300; i++) begin
      frame(4'hF, 4'h1, 128'h0, 2);
      if (i < 20) begin
        check("seq_wrap", bus.TO_SEND[DW+7 -: 4], exp_seq);
      end
      exp_seq = exp_seq + 4'd1;
    end
    check("sat_errcnt", ERR_CNT, 8'd255);

    s0 = n_start;
    drive(4'h1, 4'h1, 128'hBEEF);
    tick(2);
    RESET = 1'b1;
    tick(1);
    check("abort_reg1", reg_of(1), '0);
    check("abort_start", START, 1'b0);
    tick(2);
    RESET = 1'b0;
    tick(3);
    check("abort_tx", bus.TO_SEND, '0);
    bus.RXED = 1'b0;
    tick(4);
    check("abort_cfg", CFG, '0);
    check("abort_errcnt", ERR_CNT, 8'd0);
    check("abort_nstart", n_start - s0, 0);
    check("abort_tx2", bus.TO_SEND, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
- Command controller behind the SPI slave frame interface. It consumes each completed receive frame (RECEIVED/RXED) and decodes it into opcode, register address and data.
- It executes the command against a bank of configuration registers driven into the test-chip core, and issues a start pulse on request.
- It stages a response word on TO_SEND. The host reads that response out during the next SPI frame.

Parameters:
- DATA_W, 128, payload width per frame and width of each config register; frame LENGTH = DATA_W+8 (local constant, 136 at default).
- NREG, 4, number of config registers (1..16).

Ports:
- CLK  in  1  system clock, same clock as the SPI slave.
- RESET  in  1  synchronous, active-high reset; clock CLK.
- RECEIVED  in  DATA_W+8  last complete frame from the SPI slave; {OPC[3:0], ADDR[3:0], DATA[DATA_W-1:0]}, MSB first on the wire.
- RXED  in  1  frame-complete flag from the SPI slave; high from frame end until SSEL deasserts.
- BUSY_IN  in  1  core busy; a START is refused while this is high.
- STAT_IN  in  DATA_W  core status word, returned by the STATUS opcode.
- TO_SEND  out  DATA_W+8  response frame shifted out in the next transaction; {HDR[7:0], RDATA[DATA_W-1:0]}.
- CFG  out  NREG*DATA_W  flattened config registers; reg k occupies bits [k*DATA_W +: DATA_W].
- START  out  1  one-cycle core start pulse.
- ERR_CNT  out  8  saturating count of rejected frames.

Behaviour:
- Reset values: TO_SEND=0, CFG=0, START=0, ERR_CNT=0, frame counter SEQ=0, state IDLE.
- The RXED delay register resets to 1, so a frame that is already complete when reset releases is ignored.
- Reset mid-operation aborts the command. No partial CFG write occurs and no START pulse is issued.
- Edge detect: rise = RXED & ~RXED_D; fall = ~RXED & RXED_D.
- FSM states: IDLE, DECODE, EXEC, WAIT_END, COMMIT.
  - IDLE: on rise, latch RECEIVED into CMD_R -> DECODE.
  - DECODE (1 cycle): classify the command, set ERR_R, select RDATA -> EXEC.
  - EXEC (1 cycle): perform the side effect, build RESP_R -> WAIT_END.
  - WAIT_END: wait for fall; if RXED is already low, go straight to COMMIT.
  - COMMIT (1 cycle): TO_SEND<=RESP_R, SEQ<=SEQ+1 (wraps at 16) -> IDLE.
- TO_SEND changes only in COMMIT, i.e. after SSEL has risen, so it never changes while a frame is being shifted out.
- Latency:
  - Rise detected at cycle t; a CFG write or START pulse is visible at t+3.
  - TO_SEND updates two cycles after the cycle in which RXED goes low.
- Opcodes:
  - 0x0 NOP: RDATA=0.
  - 0x1 WRITE: CFG[ADDR]<=DATA; RDATA=DATA (echo).
  - 0x2 READ: RDATA=CFG[ADDR].
  - 0x3 START: START=1 for exactly one cycle in EXEC; RDATA=0.
  - 0x4 STATUS: RDATA=STAT_IN, sampled in DECODE.
- Error cases:
  - Any other opcode is an error.
  - WRITE or READ with ADDR>=NREG is an error.
  - START with BUSY_IN=1 (sampled in DECODE) is an error.
  - On error: no side effect, RDATA=0, ERR_CNT increments and saturates at 255.
- Response header: HDR = {SEQ[3:0], ERR_R, BUSY_IN at DECODE, OPC[1:0]}.
- A new rise arriving while the FSM is outside IDLE cannot occur: RXED must fall first. The FSM makes no provision for it.
- Back-to-back frames: COMMIT completes long before the SPI slave's first synchronised SCK edge of the next frame.
- All arithmetic is unsigned. ADDR compares against NREG as 5-bit values.

Decomposition:
- Package spi_cmd_pkg holds:
  - opcode constants OPC_NOP/WRITE/READ/START/STATUS;
  - field positions (OPC_MSB, ADDR_MSB, HDR bit indices);
  - the FSM state encoding.
- Sub-module spi_cfg_regfile (NREG x DATA_W):
  - one write port (we, addr, wdata) and one combinational read port;
  - flattened CFG output;
  - synchronous reset to zero.

Test Plan:
- Reset, then RXED held high across reset release with RECEIVED={0x1,0x0,DATA=0xA5..}: no CFG change, ERR_CNT=0, TO_SEND=0.
- WRITE addr 2 data 0x1234, then READ addr 2: CFG reg2=0x1234 at t+3. After the second frame, TO_SEND=={HDR={SEQ=1,0,0,2'b10}, 0x1234}.
- START with BUSY_IN=0: exactly one START-high cycle. Repeat with BUSY_IN=1: no pulse, ERR_CNT=1, HDR[3]=1, HDR[2]=1.
- WRITE addr 7 (NREG=4) and opcode 0xF: no CFG change, RDATA=0, ERR_CNT increments by 2.
- STATUS with STAT_IN=0xDEAD_BEEF: RDATA=0xDEADBEEF. TO_SEND stays stable while RXED is high and updates 2 cycles after the RXED fall.
- 300 bad frames: ERR_CNT saturates at 255. SEQ wraps from 15 to 0. RESET asserted in EXEC of a WRITE: CFG remains 0.
